seq_mag_comparator: RTL and testbench



---
 rtl/seq_mag_comparator.sv | 69 ++++++
 tb/tb_seq_mag_comparator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, early exit on first differing slice
module seq_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1,
  parameter int CW    = $clog2(WIDTH / DIGIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [CW-1:0]    nslices
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic {IDLE, CMP} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_sa, w_sb;
  logic             w_last;
  // Operands shift left each step, so the slice under test is always the top DIGIT bits
  assign w_sa   = r_a[WIDTH-1 -: DIGIT];
  assign w_sb   = r_b[WIDTH-1 -: DIGIT];
  assign w_last = r_cnt == CW'(NDIG - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lt      <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      nslices <= '0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_a     <= signed_mode ? a ^ MSB : a;
          r_b     <= signed_mode ? b ^ MSB : b;
          r_cnt   <= '0;
          busy    <= 1'b1;
          r_state <= CMP;
        end
      end else if (w_sa != w_sb || w_last) begin
        lt      <= w_sa < w_sb;
        gt      <= w_sa > w_sb;
        eq      <= w_sa == w_sb;
        nslices <= r_cnt + CW'(1);
        done    <= 1'b1;
        busy    <= 1'b0;
        r_state <= IDLE;
      end else begin
        r_a   <= r_a << DIGIT;
        r_b   <= r_b << DIGIT;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: table-driven vectors on DIGIT=1 and DIGIT=4 instances plus handshake/abort sequences
module tb_seq_mag_comparator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0, sm = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy0, done0, lt0, gt0, eq0;
  logic       busy1, done1, lt1, gt1, eq1;
  logic [3:0] ns0;
  logic [1:0] ns1;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm), .a(a), .b(b),
    .busy(busy0), .done(done0), .lt(lt0), .gt(gt0), .eq(eq0), .nslices(ns0));
  seq_mag_comparator #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm), .a(a), .b(b),
    .busy(busy1), .done(done1), .lt(lt1), .gt(gt1), .eq(eq1), .nslices(ns1));

  typedef struct {
    bit       sel;
    bit       sm;
    bit [7:0] a;
    bit [7:0] b;
    bit [2:0] flags;
    int       ns;
  } vec_t;

  function automatic bit [2:0] fl(bit s);
    return s ? {lt1, gt1, eq1} : {lt0, gt0, eq0};
  endfunction
  function automatic int nsl(bit s);
    return s ? int'(ns1) : int'(ns0);
  endfunction
  function automatic bit bsy(bit s);
    return s ? busy1 : busy0;
  endfunction
  function automatic bit dn(bit s);
    return s ? done1 : done0;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic go(bit s, bit m, bit [7:0] va, bit [7:0] vb);
    @(negedge clk);
    sm = m; a = va; b = vb;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0;
    check("busy_after_start", bsy(s), 1);
  endtask

  task automatic wait_done(bit s, output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (dn(s)) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_vec(vec_t v);
    int k;
    go(v.sel, v.sm, v.a, v.b);
    wait_done(v.sel, k);
    check("latency", k, v.ns);
    check("flags_lt_gt_eq", fl(v.sel), v.flags);
    check("nslices", nsl(v.sel), v.ns);
    check("busy_at_done", bsy(v.sel), 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", dn(v.sel), 0);
    check("flags_held", fl(v.sel), v.flags);
  endtask

  initial begin
    vec_t vt[12];
    int   k, cnt;
    vt[0]  = '{0, 0, 8'hA5, 8'hA5, 3'b001, 8};
    vt[1]  = '{0, 0, 8'h80, 8'h7F, 3'b010, 1};
    vt[2]  = '{0, 1, 8'h80, 8'h7F, 3'b100, 1};
    vt[3]  = '{0, 0, 8'h10, 8'h30, 3'b100, 3};
    vt[4]  = '{0, 0, 8'h13, 8'h12, 3'b010, 8};
    vt[5]  = '{0, 1, 8'hFF, 8'hFE, 3'b010, 8};
    vt[6]  = '{1, 0, 8'h3C, 8'h3D, 3'b100, 2};
    vt[7]  = '{1, 1, 8'h9C, 8'h1C, 3'b100, 1};
    vt[8]  = '{0, 1, 8'h7F, 8'h80, 3'b010, 1};
    vt[9]  = '{1, 0, 8'h00, 8'h00, 3'b001, 2};
    vt[10] = '{1, 1, 8'h80, 8'h7F, 3'b100, 1};
    vt[11] = '{0, 0, 8'h00, 8'hFF, 3'b100, 1};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_flags", fl(0), 0);
    check("reset_nslices", nsl(0), 0);
    check("reset_flags_d4", fl(1), 0);
    foreach (vt[i]) run_vec(vt[i]);
    // start pulsed mid-compare is ignored; start in the done cycle is accepted
    go(0, 0, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    a = 8'h01; b = 8'h02; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_done(0, k);
    check("busy_start_latency", k, 6);
    check("busy_start_flags", fl(0), 3'b001);
    check("busy_start_nslices", nsl(0), 8);
    a = 8'hF0; b = 8'h0F; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("b2b_done_low", done0, 0);
    check("b2b_busy", busy0, 1);
    @(posedge clk);
    #1;
    check("b2b_done", done0, 1);
    check("b2b_flags", fl(0), 3'b010);
    check("b2b_nslices", nsl(0), 1);
    // reset mid-compare aborts without a done pulse
    go(0, 0, 8'h55, 8'h55);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_flags", fl(0), 0);
    check("abort_nslices", nsl(0), 0);
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done0) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run_vec('{0, 0, 8'h80, 8'h7F, 3'b010, 1});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
